// File: rtl/cpu_hazard_pkg.sv
// rtl/cpu_hazard_pkg.sv - shared state encoding, redirect codes and counter sizing for the hazard controller
package cpu_hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

    localparam logic REDIR_JMP = 1'b0;
    localparam logic REDIR_BR  = 1'b1;

    // Bits needed to hold a countdown from lat down to zero.
    function automatic int cnt_width(input int lat);
        int w;
        w = $clog2(lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register countdown of pending load writebacks with load-use hazard flag
module hazard_scoreboard
    import cpu_hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  rd0_en,
    input  logic [REG_ADDR_W-1:0] rd0_addr,
    input  logic                  rd1_en,
    input  logic [REG_ADDR_W-1:0] rd1_addr,
    output logic                  hazard
);

    localparam int CW   = cnt_width(LOAD_LAT);
    localparam int NREG = 1 << REG_ADDR_W;

    logic [CW-1:0] cnt [NREG];

    // A fresh load overrides the decrement of the same entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (set_en && (set_addr == REG_ADDR_W'(i))) begin
                    cnt[i] <= CW'(LOAD_LAT);
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign hazard = (rd0_en && (cnt[rd0_addr] != '0)) ||
                    (rd1_en && (cnt[rd1_addr] != '0));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - stall/flush arbitration and halt-drain FSM; HAZARD_PERF_EN adds a stall cycle counter
module hazard_ctrl_unit
    import cpu_hazard_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int REG_ADDR_W = 4,
    parameter int LOAD_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_src0_addr,
    input  logic                  id_src0_used,
    input  logic [REG_ADDR_W-1:0] id_src1_addr,
    input  logic                  id_src1_used,
    input  logic [REG_ADDR_W-1:0] id_dst_addr,
    input  logic                  id_we,
    input  logic                  id_is_load,
    input  logic                  id_is_hlt,
    input  logic                  jmp_id,
    input  logic                  br_taken_ex,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  bubble_ex,
    output logic                  flush_if_id,
    output logic                  redirect_valid,
    output logic                  redirect_sel,
    output logic                  id_issue,
    output logic                  hlt
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]           stall_cycles
`endif
);

    localparam int DW = 3;
    // Loaded on the HLT issue edge so hlt rises NUM_STAGES-2 edges later.
    localparam logic [DW-1:0] DRAIN_INIT = DW'(NUM_STAGES - 3);

    hz_state_t     state, state_nxt;
    logic [DW-1:0] drain_cnt;
    logic          hlt_q;
    logic          sb_hazard;
    logic          load_hzd;

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .LOAD_LAT   (LOAD_LAT)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (id_issue && id_is_load && id_we),
        .set_addr (id_dst_addr),
        .rd0_en   (id_valid && id_src0_used),
        .rd0_addr (id_src0_addr),
        .rd1_en   (id_valid && id_src1_used),
        .rd1_addr (id_src1_addr),
        .hazard   (sb_hazard)
    );

    assign load_hzd = id_valid && sb_hazard;
    assign hlt      = hlt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            hlt_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_RUN) begin
                drain_cnt <= DRAIN_INIT;
            end else if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end
            hlt_q <= (state_nxt == ST_HALTED);
        end
    end

    always_comb begin
        state_nxt      = state;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        bubble_ex      = 1'b0;
        flush_if_id    = 1'b0;
        redirect_valid = 1'b0;
        redirect_sel   = REDIR_JMP;
        id_issue       = 1'b0;
        if (rst_n) begin
            case (state)
                ST_RUN: begin
                    // The branch in EX is older than anything in ID, so it wins.
                    if (br_taken_ex) begin
                        flush_if_id    = 1'b1;
                        bubble_ex      = 1'b1;
                        redirect_valid = 1'b1;
                        redirect_sel   = REDIR_BR;
                    end else if (load_hzd) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (id_valid) begin
                        id_issue = 1'b1;
                        if (jmp_id) begin
                            flush_if_id    = 1'b1;
                            redirect_valid = 1'b1;
                            redirect_sel   = REDIR_JMP;
                        end
                        if (id_is_hlt) begin
                            state_nxt = ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (drain_cnt == '0) begin
                        state_nxt = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((state == ST_RUN) && (load_hzd || br_taken_ex) &&
                     (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed bench for hazard_ctrl_unit at LOAD_LAT=1 and LOAD_LAT=3
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [3:0] id_src0_addr;
    logic       id_src0_used;
    logic [3:0] id_src1_addr;
    logic       id_src1_used;
    logic [3:0] id_dst_addr;
    logic       id_we;
    logic       id_is_load;
    logic       id_is_hlt;
    logic       jmp_id;
    logic       br_taken_ex;

    logic stall_if_a, stall_id_a, bubble_ex_a, flush_a, rv_a, rs_a, issue_a, hlt_a;
    logic stall_if_b, stall_id_b, bubble_ex_b, flush_b, rv_b, rs_b, issue_b, hlt_b;
    logic [7:0] oa, ob;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
    logic [15:0] sc_a, sc_b;
`endif

    hazard_ctrl_unit #(.NUM_STAGES(5), .REG_ADDR_W(4), .LOAD_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src0_addr(id_src0_addr), .id_src0_used(id_src0_used),
        .id_src1_addr(id_src1_addr), .id_src1_used(id_src1_used),
        .id_dst_addr(id_dst_addr), .id_we(id_we), .id_is_load(id_is_load),
        .id_is_hlt(id_is_hlt), .jmp_id(jmp_id), .br_taken_ex(br_taken_ex),
        .stall_if(stall_if_a), .stall_id(stall_id_a), .bubble_ex(bubble_ex_a),
        .flush_if_id(flush_a), .redirect_valid(rv_a), .redirect_sel(rs_a),
        .id_issue(issue_a), .hlt(hlt_a)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(sc_a)
`endif
    );

    hazard_ctrl_unit #(.NUM_STAGES(5), .REG_ADDR_W(4), .LOAD_LAT(3)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_src0_addr(id_src0_addr), .id_src0_used(id_src0_used),
        .id_src1_addr(id_src1_addr), .id_src1_used(id_src1_used),
        .id_dst_addr(id_dst_addr), .id_we(id_we), .id_is_load(id_is_load),
        .id_is_hlt(id_is_hlt), .jmp_id(jmp_id), .br_taken_ex(br_taken_ex),
        .stall_if(stall_if_b), .stall_id(stall_id_b), .bubble_ex(bubble_ex_b),
        .flush_if_id(flush_b), .redirect_valid(rv_b), .redirect_sel(rs_b),
        .id_issue(issue_b), .hlt(hlt_b)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(sc_b)
`endif
    );

    // {stall_if, stall_id, bubble_ex, flush_if_id, redirect_valid, redirect_sel, id_issue, hlt}
    assign oa = {stall_if_a, stall_id_a, bubble_ex_a, flush_a, rv_a, rs_a, issue_a, hlt_a};
    assign ob = {stall_if_b, stall_id_b, bubble_ex_b, flush_b, rv_b, rs_b, issue_b, hlt_b};

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_src0_addr = 4'd0;
        id_src0_used = 1'b0;
        id_src1_addr = 4'd0;
        id_src1_used = 1'b0;
        id_dst_addr  = 4'd0;
        id_we        = 1'b0;
        id_is_load   = 1'b0;
        id_is_hlt    = 1'b0;
        jmp_id       = 1'b0;
        br_taken_ex  = 1'b0;
    endtask

    // Inputs are applied 1 time unit after the rising edge; outputs checked 1 unit later.
    task automatic cyc(input string tag, input logic [7:0] ea, input logic [7:0] eb);
        #1;
        check({tag, "_a"}, int'(oa), int'(ea));
        check({tag, "_b"}, int'(ob), int'(eb));
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] r);
        idle(); id_valid = 1'b1; id_dst_addr = r; id_we = 1'b1; id_is_load = 1'b1;
    endtask

    task automatic read0(input logic [3:0] r);
        idle(); id_valid = 1'b1; id_src0_addr = r; id_src0_used = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        id_valid = 1'b1; br_taken_ex = 1'b1;
        cyc("in_reset", 8'h00, 8'h00);
        rst_n = 1'b1;
        idle();
        cyc("after_reset", 8'h00, 8'h00);

        // load-use stall: 1 cycle at LOAD_LAT=1, 3 cycles at LOAD_LAT=3
        load(4'd3);
        cyc("ld_r3", 8'h02, 8'h02);
        read0(4'd3); id_dst_addr = 4'd4; id_we = 1'b1;
        cyc("use1", 8'hE0, 8'hE0);
        cyc("use2", 8'h02, 8'hE0);
        cyc("use3", 8'h02, 8'hE0);
        cyc("use4", 8'h02, 8'h02);

        // ALU dependence never stalls; register 0 is an ordinary register
        idle(); id_valid = 1'b1; id_dst_addr = 4'd6; id_we = 1'b1;
        cyc("alu_wr", 8'h02, 8'h02);
        idle(); id_valid = 1'b1; id_src1_addr = 4'd6; id_src1_used = 1'b1;
        cyc("alu_rd", 8'h02, 8'h02);
        load(4'd0);
        cyc("ld_r0", 8'h02, 8'h02);
        read0(4'd0);
        cyc("use_r0", 8'hE0, 8'hE0);
        idle(); id_valid = 1'b1;
        cyc("unused_src", 8'h02, 8'h02);
        idle();
        cyc("idle1", 8'h00, 8'h00);

        // branch beats a load-use hazard; the squashed load of R7 is not recorded
        load(4'd3);
        cyc("ld_r3b", 8'h02, 8'h02);
        load(4'd7); id_src0_addr = 4'd3; id_src0_used = 1'b1; br_taken_ex = 1'b1;
        cyc("br_hzd", 8'h3C, 8'h3C);
        read0(4'd3);
        cyc("after_br", 8'h02, 8'hE0);
        read0(4'd7);
        cyc("r7_clear", 8'h02, 8'h02);

        // redirect arbitration
        idle(); id_valid = 1'b1; jmp_id = 1'b1; br_taken_ex = 1'b1;
        cyc("jmp_br", 8'h3C, 8'h3C);
        idle(); id_valid = 1'b1; jmp_id = 1'b1;
        cyc("jmp", 8'h1A, 8'h1A);
        load(4'd2);
        cyc("ld_r2", 8'h02, 8'h02);
        idle(); id_valid = 1'b1; id_src1_addr = 4'd2; id_src1_used = 1'b1; jmp_id = 1'b1;
        cyc("jmp_hzd", 8'hE0, 8'hE0);
        cyc("jmp_go1", 8'h1A, 8'hE0);
        cyc("jmp_go2", 8'h1A, 8'hE0);
        cyc("jmp_go3", 8'h1A, 8'h1A);

        // HLT squashed by a branch, then a real halt drain
        idle(); id_valid = 1'b1; id_is_hlt = 1'b1; br_taken_ex = 1'b1;
        cyc("hlt_br", 8'h3C, 8'h3C);
        idle();
        cyc("no_hlt", 8'h00, 8'h00);
        idle(); id_valid = 1'b1; id_is_hlt = 1'b1;
        cyc("hlt_iss", 8'h02, 8'h02);
        idle(); id_valid = 1'b1;
        cyc("drain1", 8'hE0, 8'hE0);
        cyc("drain2", 8'hE0, 8'hE0);
        cyc("drain3", 8'hE0, 8'hE0);
        cyc("halt", 8'hE1, 8'hE1);
        cyc("halt_hold", 8'hE1, 8'hE1);

        // reset out of HALTED and out of DRAIN with a load still pending
        rst_n = 1'b0; idle();
        cyc("rst_halted", 8'h01, 8'h01);
        rst_n = 1'b1;
        cyc("post_rst", 8'h00, 8'h00);
        load(4'd5);
        cyc("ld_r5", 8'h02, 8'h02);
        idle(); id_valid = 1'b1; id_is_hlt = 1'b1;
        cyc("hlt2", 8'h02, 8'h02);
        idle();
        cyc("drain_b", 8'hE0, 8'hE0);
        rst_n = 1'b0;
        cyc("rst_drain", 8'h00, 8'h00);
        rst_n = 1'b1;
        read0(4'd5);
        cyc("r5_free", 8'h02, 8'h02);

`ifdef HAZARD_PERF_EN
        check("perf_zero_a", int'(sc_a), 0);
        check("perf_zero_b", int'(sc_b), 0);
        idle(); id_valid = 1'b1; br_taken_ex = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc("perf_br", 8'h3C, 8'h3C);
        end
        check("perf_four_a", int'(sc_a), 4);
        check("perf_four_b", int'(sc_b), 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised hazard, stall and flush controller for the in-order pipelined CPU. It replaces the fixed per-stage stall generator with a scoreboard of pending load writebacks, branch/jump flush arbitration and a halt-drain state machine. It sits beside the forwarding unit and drives the PC hold, the IF/ID hold and flush, and the ID/EX bubble. Register depth, pipeline depth and load latency are all generalised.

Parameters:
NUM_STAGES, 5, pipeline depth IF..WB; legal range 4..8.
REG_ADDR_W, 4, register address width; the scoreboard has 2**REG_ADDR_W entries.
LOAD_LAT, 1, load-use stall cycles needed before the load result is forwardable; legal range 1..3.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
id_valid  in  1  valid instruction in ID
id_src0_addr  in  REG_ADDR_W  first source register
id_src0_used  in  1  first source is read
id_src1_addr  in  REG_ADDR_W  second source register
id_src1_used  in  1  second source is read
id_dst_addr  in  REG_ADDR_W  destination register
id_we  in  1  ID instruction writes the register file
id_is_load  in  1  ID instruction is a load
id_is_hlt  in  1  ID instruction is HLT
jmp_id  in  1  jump decoded in ID
br_taken_ex  in  1  branch resolved taken in EX
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
bubble_ex  out  1  load NOP into ID/EX
flush_if_id  out  1  squash IF/ID contents
redirect_valid  out  1  PC redirect this cycle
redirect_sel  out  1  redirect source: 0 = jump, 1 = branch
id_issue  out  1  ID instruction advances to EX at this edge
hlt  out  1  processor halted (registered)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Scoreboard cleared; state = RUN; hlt = 0.
  - While rst_n=0, all combinational outputs are forced to 0.
- Scoreboard: one countdown per register, each ceil(log2(LOAD_LAT+1)) bits. Nonzero counters decrement every cycle, saturating at 0.
- Issue condition: id_issue = id_valid & ~load_hzd & ~br_taken_ex & state==RUN.
- On id_issue with id_is_load & id_we, cnt[id_dst_addr] <= LOAD_LAT. This load wins over the decrement of the same entry.
- Load-use hazard: load_hzd = id_valid & ((src0_used & cnt[src0]!=0) | (src1_used & cnt[src1]!=0)).
  - A dependence on a non-load write never stalls; forwarding covers it.
  - Register 0 receives no special treatment.
- Load-use stall (load_hzd & ~br_taken_ex): stall_if=1, stall_id=1, bubble_ex=1.
- Priority, highest first:
  1. br_taken_ex: flush_if_id=1, bubble_ex=1, stall_if=0, stall_id=0, redirect_valid=1, redirect_sel=1. A jmp_id in the same cycle is ignored; the branch is older.
  2. load_hzd: stall as above; jmp_id is not acted on until the stall clears.
  3. jmp_id & id_issue: flush_if_id=1, redirect_valid=1, redirect_sel=0.
- Halt FSM, states RUN, DRAIN, HALTED (2-bit):
  - RUN -> DRAIN on id_issue & id_is_hlt. An HLT in ID alongside br_taken_ex is squashed and no transition occurs.
  - DRAIN: stall_if=1, stall_id=1, bubble_ex=1, id_issue=0. A drain counter lets older instructions retire.
  - hlt rises exactly NUM_STAGES-2 cycles after the issue edge (3 for the default), and the state becomes HALTED.
  - HALTED: hlt=1, front end held; remains until reset.
  - Scoreboard counters keep decrementing during DRAIN and HALTED.
- Reset asserted in any state returns to RUN on the next edge, regardless of pending counters.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds output stall_cycles (16 bits), reset to 0.
  - Increments in every cycle with a load-use stall or br_taken_ex flush while state==RUN.
  - Saturates at 16'hFFFF.
  - Register file writes are unaffected.
- When undefined, the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_hazard_pkg holds:
  - state encoding localparams ST_RUN=0, ST_DRAIN=1, ST_HALTED=2;
  - REDIR_JMP=0, REDIR_BR=1;
  - the counter-width helper function.
- One sub-module, hazard_scoreboard, implements the per-register countdown array with set port, two read ports and a hazard flag output.
- Arbitration and the FSM stay in hazard_ctrl_unit.

Test Plan:
1. Load-use stall: LD R3 issued, then next cycle ADD reading R3 (LOAD_LAT=1) -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle, then id_issue=1. With LOAD_LAT=3 -> 3 stall cycles.
2. ALU dependence: ADD writing R3, then ADD reading R3 -> no stall; id_issue=1 on consecutive cycles.
3. Branch over stall: br_taken_ex=1 in the same cycle as a load-use hazard -> flush_if_id=1, bubble_ex=1, stall_if=0, redirect_sel=1, id_issue=0; scoreboard unchanged.
4. Redirect arbitration: jmp_id=1 and br_taken_ex=1 together -> redirect_sel=1, one redirect only. jmp_id alone with no hazard -> flush_if_id=1, redirect_sel=0.
5. Halt drain: HLT issued at edge t (NUM_STAGES=5) -> stall_if=1 from t, hlt=1 from t+3 and held. An HLT in ID alongside br_taken_ex -> hlt stays 0.
6. Reset mid-operation: rst_n=0 for 1 cycle during DRAIN with cnt[R5]=1 -> state RUN, hlt=0, a subsequent read of R5 does not stall. With HAZARD_PERF_EN, stall_cycles=0 after reset and equals 4 after 4 stall cycles.
